// File: rtl/transpose_ctrl.sv
// Ping-pong 8x8 transpose flow control: row-major samples in, column-major samples out, 2-cycle bank-full-to-output latency.
// Input stalls while the write bank is full; reads are credit-gated against a 2-entry fall-through skid FIFO so out_ready backpressure never drops data.
module transpose_ctrl #(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              mem_wren,
    output logic [6:0]        mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rden,
    output logic [6:0]        mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        bank_full
);

    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    logic [1:0]             bank_full_q, bank_full_d;
    logic                   wbank_q, wbank_d;
    logic                   rbank_q, rbank_d;
    logic [5:0]             wcnt_q, wcnt_d;
    logic [5:0]             rcnt_q, rcnt_d;
    logic                   inflight_q, inflight_d;
    logic                   inflight_last_q, inflight_last_d;
    logic [1:0]             occ_q, occ_d;
    logic [1:0][DATA_W-1:0] slot_dat_q, slot_dat_d;
    logic [1:0]             slot_last_q, slot_last_d;

    logic       accept;
    logic       issue;
    logic       pop;
    logic       pop_store;
    logic       push_store;
    logic [1:0] occ_mid;
    logic [2:0] credit;

    always_comb begin
        in_ready  = !rst && !bank_full_q[wbank_q];
        accept    = in_valid && in_ready;

        // The read returning this cycle is visible at the output before it is stored.
        out_valid = !rst && ((occ_q != 2'd0) || inflight_q);
        out_data  = (occ_q != 2'd0) ? slot_dat_q[0] : mem_rdata;
        out_last  = (occ_q != 2'd0) ? slot_last_q[0] : inflight_last_q;
        pop       = out_valid && out_ready;

        credit    = {1'b0, occ_q} - {2'b0, pop} + {2'b0, inflight_q};
        issue     = !rst && bank_full_q[rbank_q] && (credit < DEPTH);

        mem_wren  = accept;
        mem_waddr = {wbank_q, wcnt_q};
        mem_wdata = in_data;
        mem_rden  = issue;
        mem_raddr = {rbank_q, rcnt_q[2:0], rcnt_q[5:3]};
        bank_full = bank_full_q;

        bank_full_d = bank_full_q;
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;

        if (accept) begin
            wcnt_d = wcnt_q + 6'd1;
            if (wcnt_q == 6'd63) begin
                bank_full_d[wbank_q] = 1'b1;
                wbank_d              = !wbank_q;
            end
        end

        // Set and clear always hit different banks, so both can apply in one cycle.
        if (issue) begin
            rcnt_d = rcnt_q + 6'd1;
            if (rcnt_q == 6'd63) begin
                bank_full_d[rbank_q] = 1'b0;
                rbank_d              = !rbank_q;
            end
        end

        inflight_d      = issue;
        inflight_last_d = issue && (rcnt_q == 6'd63);

        pop_store   = pop && (occ_q != 2'd0);
        push_store  = inflight_q && !(pop && (occ_q == 2'd0));
        occ_mid     = occ_q - {1'b0, pop_store};
        slot_dat_d  = slot_dat_q;
        slot_last_d = slot_last_q;
        if (pop_store) begin
            slot_dat_d[0]  = slot_dat_q[1];
            slot_last_d[0] = slot_last_q[1];
        end
        if (push_store) begin
            slot_dat_d[occ_mid[0]]  = mem_rdata;
            slot_last_d[occ_mid[0]] = inflight_last_q;
        end
        occ_d = occ_mid + {1'b0, push_store};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full_q     <= 2'b00;
            wbank_q         <= 1'b0;
            rbank_q         <= 1'b0;
            wcnt_q          <= 6'd0;
            rcnt_q          <= 6'd0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            occ_q           <= 2'd0;
            slot_dat_q      <= '0;
            slot_last_q     <= 2'b00;
        end else begin
            bank_full_q     <= bank_full_d;
            wbank_q         <= wbank_d;
            rbank_q         <= rbank_d;
            wcnt_q          <= wcnt_d;
            rcnt_q          <= rcnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            occ_q           <= occ_d;
            slot_dat_q      <= slot_dat_d;
            slot_last_q     <= slot_last_d;
        end
    end

endmodule
